// File: rtl/fsm_rr_pkg.sv
// Shared types and width helpers for the round-robin arbiter slice.
package fsm_rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Index/counter widths never collapse to zero bits, even when N or MAX_HOLD is 1.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Request/release/grant bundle between requesting FSMs and the arbiter.
interface fsm_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IDX_W = fsm_rr_pkg::clog2_min1(N);

    logic [N-1:0]     req;
    logic [N-1:0]     rel;
    logic [N-1:0]     gnt;
    logic             busy;
    logic [IDX_W-1:0] owner;
    logic             timeout;

    modport master (output req, rel, input gnt, busy, owner, timeout);
    modport slave  (input req, rel, output gnt, busy, owner, timeout);
endinterface

// File: rtl/fsm_rr_pick.sv
// Rotating priority picker: first set req bit strictly after ptr, with wrap-around.
module fsm_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        int j;
        j      = 0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                valid     = 1'b1;
                idx       = IDX_W'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter with a one-cycle handover gap and optional hold timeout.
module fsm_rr_arbiter
    import fsm_rr_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = clog2_min1(N),
    parameter int CNT_W    = clog2_min1(MAX_HOLD + 1)
) (
    input logic             clk,
    input logic             rst,
    fsm_rr_arbiter_if.slave bus
);

    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;
    logic             rel_own, req_own, hold_hit;

    fsm_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx),
        .onehot(pick_onehot)
    );

    assign rel_own  = bus.rel[bus.owner];
    assign req_own  = bus.req[bus.owner];
    assign hold_hit = (MAX_HOLD != 0) && (cnt == CNT_W'(HOLD_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            bus.owner   <= '0;
            bus.timeout <= 1'b0;
            cnt         <= '0;
            ptr         <= IDX_W'(N - 1);
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        bus.gnt   <= pick_onehot;
                        bus.busy  <= 1'b1;
                        bus.owner <= pick_idx;
                        cnt       <= '0;
                    end
                end
                GRANT: begin
                    if (rel_own || !req_own || hold_hit) begin
                        state       <= GAP;
                        bus.gnt     <= '0;
                        bus.busy    <= 1'b0;
                        ptr         <= bus.owner;
                        // A voluntary release in the same cycle masks the timeout flag.
                        bus.timeout <= hold_hit && !rel_own && req_own;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: begin
                    state    <= IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Scenario bench for fsm_rr_arbiter: per-feature tasks plus a grant-order scoreboard.
module tb_fsm_rr_arbiter;
    import fsm_rr_pkg::*;

    localparam int N  = 4;
    localparam int MH = 4;

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   o;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t e;
    logic [N-1:0] prev_gnt = '0;

    fsm_rr_arbiter_if #(.N(N)) bus ();

    fsm_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i);
        exp_t x;
        x.g = N'(1 << i);
        x.o = 2'(i);
        q.push_back(x);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (bus.busy !== (|bus.gnt) || !$onehot0(bus.gnt)) begin
                bad++;
                $display("FAIL invariant: gnt=%b busy=%b", bus.gnt, bus.busy);
            end
            total++;
            if ((bus.gnt != '0) !== (dut.state == GRANT)) begin
                bad++;
                $display("FAIL gnt_vs_state: gnt=%b state=%0d", bus.gnt, dut.state);
            end
            if (bus.gnt != '0 && prev_gnt == '0) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: gnt=%b owner=%0d, no grant expected", bus.gnt, bus.owner);
                end else begin
                    e = q.pop_front();
                    if (bus.gnt !== e.g || bus.owner !== e.o) begin
                        bad++;
                        $display("FAIL sb_grant: got gnt=%b owner=%0d want gnt=%b owner=%0d",
                                 bus.gnt, bus.owner, e.g, e.o);
                    end
                end
            end
        end
        prev_gnt = bus.gnt;
    end

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        tick();
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: gnt=%b busy=%b owner=%0d timeout=%b want 0000/0/0/0",
                     bus.gnt, bus.busy, bus.owner, bus.timeout);
        end
        total++;
        if (dut.state !== IDLE || dut.ptr !== 2'd3) begin
            bad++;
            $display("FAIL reset_state: state=%0d ptr=%0d want 0/3", dut.state, dut.ptr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        push_exp(0);
        tick();
        total++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b want 0001/0/1", bus.gnt, bus.owner, bus.busy);
        end
        tick();
        tick();
        bus.rel = 4'b0001;
        tick();
        bus.rel = '0;
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0000 || dut.state !== GAP || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL single_release: gnt=%b state=%0d timeout=%b want 0000/GAP/0",
                     bus.gnt, dut.state, bus.timeout);
        end
        tick();
        total++;
        if (dut.state !== IDLE || bus.owner !== 2'd0) begin
            bad++;
            $display("FAIL single_idle: state=%0d owner=%0d want IDLE/0", dut.state, bus.owner);
        end
    endtask

    task automatic test_rotation();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(order[i]);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.gnt !== N'(1 << order[i])) begin
                bad++;
                $display("FAIL rot_grant%0d: gnt=%b want owner %0d", i, bus.gnt, order[i]);
            end
            tick();
            tick();
            bus.rel = N'(1 << order[i]);
            tick();
            bus.rel = '0;
            if (i == 4) bus.req = '0;
            total++;
            if (bus.gnt !== 4'b0000 || dut.state !== GAP) begin
                bad++;
                $display("FAIL rot_gap%0d: gnt=%b state=%0d want 0000/GAP", i, bus.gnt, dut.state);
            end
            tick();
            total++;
            if (bus.gnt !== 4'b0000 || dut.state !== IDLE) begin
                bad++;
                $display("FAIL rot_idle%0d: gnt=%b state=%0d want 0000/IDLE", i, bus.gnt, dut.state);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 4'b0100;
        push_exp(2);
        push_exp(2);
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (bus.gnt !== 4'b0100 || bus.timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_hold c%0d: gnt=%b timeout=%b want 0100/0", c, bus.gnt, bus.timeout);
            end
        end
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_revoke: gnt=%b timeout=%b want 0000/1", bus.gnt, bus.timeout);
        end
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0 || dut.state !== IDLE) begin
            bad++;
            $display("FAIL to_idle: gnt=%b timeout=%b state=%0d want 0000/0/IDLE", bus.gnt, bus.timeout, dut.state);
        end
        tick();
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin
            bad++;
            $display("FAIL to_regrant: gnt=%b owner=%0d want 0100/2", bus.gnt, bus.owner);
        end
        tick();
        tick();
    endtask

    task automatic test_ignore_rel();
        do_reset();
        bus.req = 4'b0010;
        push_exp(1);
        tick();
        bus.rel = 4'b1001;
        tick();
        bus.rel = '0;
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL ign_rel: gnt=%b want 0010", bus.gnt);
        end
        tick();
        bus.req = '0;
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_reqdrop: gnt=%b timeout=%b busy=%b want 0000/0/0", bus.gnt, bus.timeout, bus.busy);
        end
        tick();
        total++;
        if (bus.owner !== 2'd1) begin
            bad++;
            $display("FAIL ign_owner_hold: owner=%0d want 1", bus.owner);
        end
    endtask

    task automatic test_release_wins();
        do_reset();
        bus.req = 4'b0010;
        push_exp(1);
        tick();
        bus.rel = 4'b0010;
        tick();
        bus.rel = '0;
        push_exp(1);
        total++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL rw_gap: gnt=%b timeout=%b want 0000/0", bus.gnt, bus.timeout);
        end
        tick();
        tick();
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rw_sole: gnt=%b want 0010", bus.gnt);
        end
        bus.req = 4'b0110;
        bus.rel = 4'b0010;
        push_exp(2);
        tick();
        bus.rel = '0;
        tick();
        tick();
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin
            bad++;
            $display("FAIL rw_next: gnt=%b owner=%0d want 0100/2", bus.gnt, bus.owner);
        end
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0100;
        push_exp(2);
        tick();
        tick();
        total++;
        if (bus.gnt !== 4'b0100) begin
            bad++;
            $display("FAIL ar_pre: gnt=%b want 0100", bus.gnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
            bad++;
            $display("FAIL ar_async: gnt=%b busy=%b owner=%0d want 0000/0/0", bus.gnt, bus.busy, bus.owner);
        end
        tick();
        rst     = 1'b0;
        bus.req = 4'b1001;
        push_exp(0);
        tick();
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
            bad++;
            $display("FAIL ar_ptr: gnt=%b owner=%0d want 0001/0", bus.gnt, bus.owner);
        end
        tick();
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_ignore_rel();
        test_release_wins();
        test_async_reset();
        tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected grants never seen, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
